up_counter: RTL and testbench



---
 rtl/up_counter.sv | 101 ++++++++++
 tb/tb_up_counter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/up_counter.sv
// up_counter: modulo-MOD_VALUE up counter with parallel load, synchronous
// clear, terminal-count flag, registered wrap pulse and optional one-shot
// halt (ONE_SHOT=1).
//
// Build option: define UP_COUNTER_WRAPCNT_EN to get a saturating 8-bit count
// of wrap pulses on wrap_count. Without it wrap_count is a constant 0 and no
// register exists behind it; the port list is the same in both builds.
module up_counter #(
  parameter int WIDTH     = 3,
  parameter int MOD_VALUE = 8,
  parameter int ONE_SHOT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic [7:0]       wrap_count
);

  // RUN counts; HALT freezes the count after a one-shot terminal count.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // Last value of the sequence; also the saturation ceiling for loads.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD_VALUE - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             wrap_reg, wrap_next;

  // State, count and wrap-pulse registers; reset dominates everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  // Next-state logic: clear beats load beats en; HALT ignores en.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (clear) begin
      state_next = RUN;
      count_next = '0;
    end else if (load) begin
      // Out-of-range loads saturate at the terminal value; loads never wrap.
      state_next = RUN;
      count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en && (state_reg == RUN)) begin
      if (count_reg == MAX_VAL) begin
        if (ONE_SHOT != 0) begin
          state_next = HALT;
        end else begin
          // Explicit return to 0 so the modulus need not be a power of two.
          count_next = '0;
          wrap_next  = 1'b1;
        end
      end else begin
        count_next = count_reg + 1'b1;
      end
    end
  end

  assign data_out = count_reg;
  assign tc       = (count_reg == MAX_VAL);
  assign wrap     = wrap_reg;
  assign done     = (state_reg == HALT);

`ifdef UP_COUNTER_WRAPCNT_EN
  logic [7:0] wcnt_reg;

  // Saturating wrap counter; bumps in step with the wrap pulse register.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wcnt_reg <= 8'd0;
    end else if (wrap_next && (wcnt_reg != 8'hFF)) begin
      wcnt_reg <= wcnt_reg + 8'd1;
    end
  end

  assign wrap_count = wcnt_reg;
`else
  assign wrap_count = 8'd0;
`endif

endmodule

// File: tb/tb_up_counter.sv
// tb_up_counter: drives three up_counter instances (mod 8 free-running,
// mod 6 free-running, mod 8 one-shot) from shared inputs. A behavioural
// model predicts each edge; predictions are queued when stimulus is applied
// and popped for comparison after the edge.
module tb_up_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] d8, d6, dos;
  logic       tc8, tc6, tcos;
  logic       w8, w6, wos;
  logic       dn8, dn6, dnos;
  logic [7:0] wc8, wc6, wcos;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  up_counter #(.WIDTH(3), .MOD_VALUE(8), .ONE_SHOT(0)) dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load),
    .load_val(load_val), .data_out(d8), .tc(tc8), .wrap(w8), .done(dn8),
    .wrap_count(wc8));

  up_counter #(.WIDTH(3), .MOD_VALUE(6), .ONE_SHOT(0)) dut_m6 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load),
    .load_val(load_val), .data_out(d6), .tc(tc6), .wrap(w6), .done(dn6),
    .wrap_count(wc6));

  up_counter #(.WIDTH(3), .MOD_VALUE(8), .ONE_SHOT(1)) dut_os (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load),
    .load_val(load_val), .data_out(dos), .tc(tcos), .wrap(wos), .done(dnos),
    .wrap_count(wcos));

  typedef struct packed {
    logic [2:0] d8;
    logic       w8;
    logic [2:0] d6;
    logic       w6;
    logic [2:0] dos;
    logic       wos;
    logic       dnos;
    logic [7:0] wc8;
  } exp_t;

  exp_t exp_q[$];

  // Model state per instance: index 0 = mod 8, 1 = mod 6, 2 = mod 8 one-shot.
  int m_d[3];
  bit m_w[3];
  bit m_h[3];
  int m_wc;
  int mods[3] = '{8, 6, 8};
  bit oneshot[3] = '{1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit c, input bit l,
                      input logic [2:0] lv);
    exp_t x;
    @(negedge clk);
    reset = r; en = e; clear = c; load = l; load_val = lv;
    for (int i = 0; i < 3; i++) begin
      if (r || c) begin
        m_d[i] = 0; m_w[i] = 1'b0; m_h[i] = 1'b0;
      end else if (l) begin
        m_d[i] = (int'(lv) >= mods[i]) ? mods[i] - 1 : int'(lv);
        m_w[i] = 1'b0; m_h[i] = 1'b0;
      end else if (e && !m_h[i]) begin
        m_w[i] = 1'b0;
        if (m_d[i] == mods[i] - 1 && oneshot[i]) m_h[i] = 1'b1;
        else begin
          m_d[i] = (m_d[i] + 1) % mods[i];
          m_w[i] = (m_d[i] == 0);
        end
      end else begin
        m_w[i] = 1'b0;
      end
    end
`ifdef UP_COUNTER_WRAPCNT_EN
    if (r || c) m_wc = 0;
    else if (m_w[0] && m_wc < 255) m_wc = m_wc + 1;
`else
    m_wc = 0;
`endif
    x.d8 = 3'(m_d[0]); x.w8 = m_w[0];
    x.d6 = 3'(m_d[1]); x.w6 = m_w[1];
    x.dos = 3'(m_d[2]); x.wos = m_w[2]; x.dnos = m_h[2];
    x.wc8 = 8'(m_wc);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 8'd1, 8'd0);
    end else begin
      x = exp_q.pop_front();
      $display("step r=%0b en=%0b clr=%0b ld=%0b lv=%0d | m8 d=%0d w=%0b | m6 d=%0d w=%0b | os d=%0d done=%0b | wc=%0d",
               r, e, c, l, lv, d8, w8, d6, w6, dos, dnos, wc8);
      chk("d8", {5'd0, d8}, {5'd0, x.d8});
      chk("tc8", {7'd0, tc8}, {7'd0, x.d8 == 3'd7});
      chk("wrap8", {7'd0, w8}, {7'd0, x.w8});
      chk("done8", {7'd0, dn8}, 8'd0);
      chk("d6", {5'd0, d6}, {5'd0, x.d6});
      chk("tc6", {7'd0, tc6}, {7'd0, x.d6 == 3'd5});
      chk("wrap6", {7'd0, w6}, {7'd0, x.w6});
      chk("dos", {5'd0, dos}, {5'd0, x.dos});
      chk("tcos", {7'd0, tcos}, {7'd0, x.dos == 3'd7});
      chk("wrapos", {7'd0, wos}, {7'd0, x.wos});
      chk("doneos", {7'd0, dnos}, {7'd0, x.dnos});
      chk("wc8", wc8, x.wc8);
    end
  endtask

  initial begin
    m_wc = 0;
    for (int i = 0; i < 3; i++) begin
      m_d[i] = 0; m_w[i] = 1'b0; m_h[i] = 1'b0;
    end
    // Reset for two edges.
    step(1, 0, 0, 0, 3'd0);
    step(1, 0, 0, 0, 3'd0);
    // Count 10 cycles through a wrap.
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 3'd0);
    // Pause for three cycles, then resume.
    step(0, 1, 0, 0, 3'd0);
    step(0, 1, 0, 0, 3'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3'd0);
    step(0, 1, 0, 0, 3'd0);
    // Load beats en; out-of-range load saturates on the mod 6 instance.
    step(0, 1, 0, 1, 3'd6);
    step(0, 1, 0, 0, 3'd0);
    step(0, 1, 0, 1, 3'd7);
    step(0, 1, 0, 0, 3'd0);
    // One-shot: count from 0 to halt, sit halted, then clear and resume.
    step(0, 0, 1, 0, 3'd0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 3'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 3'd0);
    step(0, 1, 1, 0, 3'd0);
    step(0, 1, 0, 0, 3'd0);
    step(0, 1, 0, 0, 3'd0);
    // Halt again, then leave HALT via load.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 3'd0);
    step(0, 1, 0, 1, 3'd2);
    step(0, 1, 0, 0, 3'd0);
    // Clear and load together at 3: clear wins.
    step(0, 0, 0, 1, 3'd3);
    step(0, 1, 1, 1, 3'd5);
    // Reset overrides clear/load/en.
    step(0, 1, 0, 1, 3'd4);
    step(1, 1, 1, 1, 3'd6);
    // Long run: wrap counter saturation (or stays 0 without the option).
    for (int i = 0; i < 2100; i++) step(0, 1, 0, 0, 3'd0);
    step(0, 1, 1, 0, 3'd0);
    // Mixed pseudo-random stimulus.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0,
           3'($urandom_range(0, 7)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
